// File: rtl/rf_pkg.sv
// Shared constants and FSM state type for the instruction fetch stage.
package rf_pkg;

    localparam logic [31:0] RF_NOP_WORD = 32'h0000_0000;
    localparam logic [31:0] RF_RESET_PC = 32'h0000_0000;
    localparam int unsigned RF_OPCODE_W = 7;

    typedef enum logic {
        ST_FETCH = 1'b0,
        ST_DRAIN = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry holding register for an instruction word that returns while the
// decoder is stalled. Load wins over unload so both may happen together.
module fetch_skid_buf #(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              unload,
    input  logic              flush,
    input  logic [31:0]       in_instr,
    input  logic [ADDR_W-1:0] in_pc1,
    output logic [31:0]       instr,
    output logic [ADDR_W-1:0] pc1,
    output logic              valid
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr <= '0;
            pc1   <= '0;
            valid <= 1'b0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (load) begin
            instr <= in_instr;
            pc1   <= in_pc1;
            valid <= 1'b1;
        end else if (unload) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, issues word requests over req/ack and presents
// one instruction at a time to the decoder, with redirect flush handling.
module instruction_fetch
    import rf_pkg::*;
#(
    parameter int unsigned        ADDR_W   = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC = ADDR_W'(RF_RESET_PC),
    parameter logic [31:0]        NOP_WORD = RF_NOP_WORD
) (
    input  logic              CLK,
    input  logic              RESET,
    output logic              IMEM_REQ,
    output logic [ADDR_W-1:0] IMEM_ADDR,
    input  logic              IMEM_ACK,
    input  logic [31:0]       IMEM_DATA,
    input  logic              STALL,
    input  logic              REDIRECT,
    input  logic [ADDR_W-1:0] REDIRECT_PC,
    output logic [31:0]       IR_instruction,
    output logic              IR_VALID,
    output logic [ADDR_W-1:0] IR_PC1
);

    fetch_state_t      state;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_inc;
    logic              acked;
    logic              ir_take;
    logic              raise;
    logic              skid_load;
    logic              skid_unload;
    logic              skid_valid;
    logic [31:0]       skid_instr;
    logic [ADDR_W-1:0] skid_pc1;

    always_comb begin
        acked       = IMEM_REQ && IMEM_ACK;
        pc_inc      = pc + ADDR_W'(1);
        ir_take     = !IR_VALID || !STALL;
        skid_unload = !REDIRECT && IR_VALID && !STALL && skid_valid;
        skid_load   = !REDIRECT && (state == ST_FETCH) && acked
                      && IR_VALID && (STALL || skid_valid);
        // A new request is issued only when its word is guaranteed a home.
        raise       = (state == ST_FETCH) && (!IMEM_REQ || IMEM_ACK)
                      && !skid_valid && ir_take;
    end

    fetch_skid_buf #(
        .ADDR_W (ADDR_W)
    ) u_skid (
        .clk      (CLK),
        .rst_n    (RESET),
        .load     (skid_load),
        .unload   (skid_unload),
        .flush    (REDIRECT),
        .in_instr (IMEM_DATA),
        .in_pc1   (pc_inc),
        .instr    (skid_instr),
        .pc1      (skid_pc1),
        .valid    (skid_valid)
    );

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state          <= ST_FETCH;
            pc             <= RESET_PC;
            IMEM_REQ       <= 1'b0;
            IMEM_ADDR      <= RESET_PC;
            IR_instruction <= NOP_WORD;
            IR_VALID       <= 1'b0;
            IR_PC1         <= '0;
        end else if (REDIRECT) begin
            pc             <= REDIRECT_PC;
            IR_instruction <= NOP_WORD;
            IR_VALID       <= 1'b0;
            if (state == ST_DRAIN) begin
                if (acked) begin
                    state    <= ST_FETCH;
                    IMEM_REQ <= 1'b0;
                end
            end else if (IMEM_REQ && !IMEM_ACK) begin
                // Request cannot be withdrawn; wait out the stale ack.
                state <= ST_DRAIN;
            end else begin
                IMEM_REQ  <= 1'b1;
                IMEM_ADDR <= REDIRECT_PC;
            end
        end else if (state == ST_DRAIN) begin
            if (acked) begin
                state    <= ST_FETCH;
                IMEM_REQ <= 1'b0;
            end
        end else begin
            if (acked) begin
                pc <= pc_inc;
            end
            if (ir_take) begin
                if (IR_VALID && skid_valid) begin
                    IR_instruction <= skid_instr;
                    IR_PC1         <= skid_pc1;
                    IR_VALID       <= 1'b1;
                end else if (acked) begin
                    IR_instruction <= IMEM_DATA;
                    IR_PC1         <= pc_inc;
                    IR_VALID       <= 1'b1;
                end else begin
                    IR_instruction <= NOP_WORD;
                    IR_VALID       <= 1'b0;
                end
            end
            if (raise) begin
                IMEM_REQ  <= 1'b1;
                IMEM_ADDR <= acked ? pc_inc : pc;
            end else if (acked) begin
                IMEM_REQ <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed cycle table, async reset
// sequence, then randomized traffic against an in-order instruction-stream model.
module tb_instruction_fetch;

    logic        CLK;
    logic        RESET;
    logic        IMEM_REQ;
    logic [31:0] IMEM_ADDR;
    logic        IMEM_ACK;
    logic [31:0] IMEM_DATA;
    logic        STALL;
    logic        REDIRECT;
    logic [31:0] REDIRECT_PC;
    logic [31:0] IR_instruction;
    logic        IR_VALID;
    logic [31:0] IR_PC1;

    int unsigned n_checks;
    int unsigned n_errors;

    instruction_fetch #(
        .ADDR_W   (32),
        .RESET_PC (32'h0000_0000),
        .NOP_WORD (32'h0000_0000)
    ) dut (
        .CLK            (CLK),
        .RESET          (RESET),
        .IMEM_REQ       (IMEM_REQ),
        .IMEM_ADDR      (IMEM_ADDR),
        .IMEM_ACK       (IMEM_ACK),
        .IMEM_DATA      (IMEM_DATA),
        .STALL          (STALL),
        .REDIRECT       (REDIRECT),
        .REDIRECT_PC    (REDIRECT_PC),
        .IR_instruction (IR_instruction),
        .IR_VALID       (IR_VALID),
        .IR_PC1         (IR_PC1)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    typedef struct {
        logic        ack;
        logic        stall;
        logic        redir;
        logic [31:0] rpc;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_v;
        logic [31:0] e_ir;
        logic [31:0] e_pc1;
    } vec_t;

    vec_t tbl [30];

    function automatic logic [31:0] mem_word(input logic [31:0] a, input bit rnd);
        return rnd ? (a ^ 32'h5A5A_5A5A) : (a << 25);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    logic [31:0] exp_next;
    logic        prev_hold;
    logic [31:0] prev_addr;
    logic        prev_redir;
    int unsigned consumed;

    initial begin
        n_checks = 0;
        n_errors = 0;
        RESET = 1'b0;
        IMEM_ACK = 1'b0;
        IMEM_DATA = '0;
        STALL = 1'b0;
        REDIRECT = 1'b0;
        REDIRECT_PC = '0;

        //        ack   stall redir rpc            req   addr           v     ir             pc1
        tbl[0]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h0,        1'b0, 32'h0,        32'h0};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 32'h1,        1'b1, 32'h0000_0000, 32'h1};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h1,        1'b0, 32'h0,        32'h0};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 32'h2,        1'b1, 32'h0200_0000, 32'h2};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h2,        1'b0, 32'h0,        32'h0};
        tbl[5]  = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 32'h3,        1'b1, 32'h0400_0000, 32'h3};
        tbl[6]  = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 32'h3,        1'b1, 32'h0400_0000, 32'h3};
        tbl[7]  = '{1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 32'h3,        1'b1, 32'h0400_0000, 32'h3};
        tbl[8]  = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h3,        1'b1, 32'h0400_0000, 32'h3};
        tbl[9]  = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h3,        1'b1, 32'h0400_0000, 32'h3};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h3,        1'b1, 32'h0600_0000, 32'h4};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h4,        1'b0, 32'h0,        32'h0};
        tbl[12] = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 32'h5,        1'b1, 32'h0800_0000, 32'h5};
        tbl[13] = '{1'b0, 1'b0, 1'b1, 32'h40,       1'b1, 32'h5,        1'b0, 32'h0,        32'h0};
        tbl[14] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h5,        1'b0, 32'h0,        32'h0};
        tbl[15] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h5,        1'b0, 32'h0,        32'h0};
        tbl[16] = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 32'h5,        1'b0, 32'h0,        32'h0};
        tbl[17] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h40,       1'b0, 32'h0,        32'h0};
        tbl[18] = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 32'h41,       1'b1, 32'h8000_0000, 32'h41};
        tbl[19] = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 32'h41,       1'b1, 32'h8000_0000, 32'h41};
        tbl[20] = '{1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 32'h41,       1'b1, 32'h8000_0000, 32'h41};
        tbl[21] = '{1'b1, 1'b1, 1'b1, 32'h10,       1'b1, 32'h10,       1'b0, 32'h0,        32'h0};
        tbl[22] = '{1'b1, 1'b1, 1'b1, 32'h20,       1'b1, 32'h20,       1'b0, 32'h0,        32'h0};
        tbl[23] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h20,       1'b0, 32'h0,        32'h0};
        tbl[24] = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 32'h21,       1'b1, 32'h4000_0000, 32'h21};
        tbl[25] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h21,       1'b0, 32'h0,        32'h0};
        tbl[26] = '{1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b1, 32'h21,      1'b0, 32'h0,        32'h0};
        tbl[27] = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 32'h21,       1'b0, 32'h0,        32'h0};
        tbl[28] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'hFFFF_FFFF, 1'b0, 32'h0,       32'h0};
        tbl[29] = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 32'h0,        1'b1, 32'hFE00_0000, 32'h0};

        repeat (2) @(posedge CLK);
        #1;
        chk("reset_req",   {31'd0, IMEM_REQ}, 32'd0);
        chk("reset_addr",  IMEM_ADDR, 32'h0);
        chk("reset_valid", {31'd0, IR_VALID}, 32'd0);
        chk("reset_ir",    IR_instruction, 32'h0);
        chk("reset_pc1",   IR_PC1, 32'h0);
        RESET = 1'b1;

        for (int i = 0; i < 30; i++) begin
            IMEM_ACK    = tbl[i].ack;
            IMEM_DATA   = mem_word(IMEM_ADDR, 1'b0);
            STALL       = tbl[i].stall;
            REDIRECT    = tbl[i].redir;
            REDIRECT_PC = tbl[i].rpc;
            @(posedge CLK);
            #1;
            chk($sformatf("tbl%0d_req", i),   {31'd0, IMEM_REQ}, {31'd0, tbl[i].e_req});
            chk($sformatf("tbl%0d_addr", i),  IMEM_ADDR, tbl[i].e_addr);
            chk($sformatf("tbl%0d_valid", i), {31'd0, IR_VALID}, {31'd0, tbl[i].e_v});
            chk($sformatf("tbl%0d_ir", i),    IR_instruction, tbl[i].e_ir);
            if (tbl[i].e_v)
                chk($sformatf("tbl%0d_pc1", i), IR_PC1, tbl[i].e_pc1);
        end

        // Asynchronous reset between edges with a request outstanding and IR live.
        IMEM_ACK = 1'b0;
        STALL    = 1'b0;
        REDIRECT = 1'b0;
        #3;
        RESET = 1'b0;
        #1;
        chk("async_req",   {31'd0, IMEM_REQ}, 32'd0);
        chk("async_valid", {31'd0, IR_VALID}, 32'd0);
        chk("async_addr",  IMEM_ADDR, 32'h0);
        chk("async_ir",    IR_instruction, 32'h0);
        @(posedge CLK);
        #1;
        chk("held_req", {31'd0, IMEM_REQ}, 32'd0);
        RESET = 1'b1;
        @(posedge CLK);
        #1;
        chk("restart_req",  {31'd0, IMEM_REQ}, 32'd1);
        chk("restart_addr", IMEM_ADDR, 32'h0);

        // Randomized traffic: delivered instructions must follow program order,
        // restarting at each redirect target.
        exp_next = 32'h0;
        consumed = 0;
        for (int c = 0; c < 3000; c++) begin
            STALL    = ($urandom_range(0, 3) == 0);
            REDIRECT = ($urandom_range(0, 31) == 0);
            if ($urandom_range(0, 3) == 0)
                REDIRECT_PC = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
            else
                REDIRECT_PC = $urandom;
            IMEM_ACK  = ($urandom_range(0, 1) == 1);
            IMEM_DATA = IMEM_REQ ? mem_word(IMEM_ADDR, 1'b1) : $urandom;

            if (IR_VALID && !STALL && !REDIRECT) begin
                chk("rand_ir",  IR_instruction, mem_word(exp_next, 1'b1));
                chk("rand_pc1", IR_PC1, exp_next + 32'd1);
                exp_next = exp_next + 32'd1;
                consumed++;
            end
            if (REDIRECT)
                exp_next = REDIRECT_PC;
            prev_hold  = IMEM_REQ && !IMEM_ACK;
            prev_addr  = IMEM_ADDR;
            prev_redir = REDIRECT;

            @(posedge CLK);
            #1;
            if (prev_redir) begin
                chk("rand_flush_valid", {31'd0, IR_VALID}, 32'd0);
                chk("rand_flush_ir", IR_instruction, 32'h0);
            end
            if (prev_hold) begin
                chk("rand_req_hold", {31'd0, IMEM_REQ}, 32'd1);
                chk("rand_addr_hold", IMEM_ADDR, prev_addr);
            end
        end
        n_checks++;
        if (consumed < 100) begin
            n_errors++;
            $display("FAIL rand_progress: got %0d instructions expected at least 100", consumed);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
